// File: rtl/producer_addr_gen_pkg.sv
// Shared types for the producer address generator: queue control types,
// the queue configuration record, and the element-stride helpers.

package fifo_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int SIZE_W = 3;
  localparam int PTR_W  = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [SIZE_W-1:0] size_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

endpackage : fifo_ctrl_pkg

package fifo_config_pkg;

  import fifo_ctrl_pkg::*;

  // element_size holds (stride in bytes - 1); queue_size is in entries
  typedef struct packed {
    addr_t addr_base;
    size_t element_size;
    ptr_t  queue_size;
  } fifo_config_t;

endpackage : fifo_config_pkg

package producer_addr_gen_pkg;

  import fifo_ctrl_pkg::*;

  // Only 1, 2, 4 and 8 byte elements are supported
  function automatic logic size_legal(input size_t es);
    return (es == 3'd0) || (es == 3'd1) || (es == 3'd3) || (es == 3'd7);
  endfunction

  // log2 of the stride for a legal element_size; illegal codes map to 0
  function automatic logic [1:0] stride_shift(input size_t es);
    logic [1:0] sh;
    case (es)
      3'd1:    sh = 2'd1;
      3'd3:    sh = 2'd2;
      3'd7:    sh = 2'd3;
      default: sh = 2'd0;
    endcase
    return sh;
  endfunction

endpackage : producer_addr_gen_pkg

// File: rtl/producer_addr_gen_if.sv
// Decoupled valid/ready stream. The master drives valid and data, the
// slave answers with ready; a beat moves when both are high at a clock edge.

interface decoupled_vr_if #(
  parameter int WIDTH_P = 64
);

  logic               valid;
  logic               ready;
  logic [WIDTH_P-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface : decoupled_vr_if

// File: rtl/producer_addr_gen_ring_ptr_inc.sv
// Ring index increment: next(p) = (p == size-1) ? 0 : p+1. Purely
// combinational so the same helper serves the issue pointer, the commit
// pointer and the full test.

module ring_ptr_inc #(
  parameter int WIDTH_P = 16
) (
  input  logic [WIDTH_P-1:0] i_ptr,
  input  logic [WIDTH_P-1:0] i_size,
  output logic [WIDTH_P-1:0] o_next
);

  logic [WIDTH_P-1:0] w_last;

  assign w_last = i_size - WIDTH_P'(1);

  // Wrap to zero after the last entry of the ring
  always_comb begin
    o_next = i_ptr + WIDTH_P'(1);
    if (i_ptr == w_last) begin
      o_next = '0;
    end
  end

endmodule : ring_ptr_inc

// File: rtl/producer_addr_gen.sv
// Producer address generator. Takes accelerator output elements, stamps
// each with its ring-buffer address, and offers address and data together
// to the TRI adapter through a one-entry hold register. Tracks queue
// fullness against the consumer head, counts store acks, and publishes the
// committed tail index.

module producer_addr_gen
  import fifo_ctrl_pkg::*;
  import fifo_config_pkg::*;
  import producer_addr_gen_pkg::*;
#(
  parameter int DATABUS_WIDTH_P   = 64,
  parameter int PTR_W_P           = PTR_W,
  parameter int MAX_OUTSTANDING_P = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  fifo_config_t         fifo_config_r,
  input  logic                 enable,
  decoupled_vr_if.slave        acc_in,
  input  logic [PTR_W_P-1:0]   consumer_head,
  decoupled_vr_if.master       trans,
  decoupled_vr_if.master       acc_data,
  input  logic                 trans_ack,
  output logic [PTR_W_P-1:0]   commit_tail,
  output logic                 tail_update,
  output logic                 idle
);

  localparam int                OUT_W   = $clog2(MAX_OUTSTANDING_P) + 1;
  localparam logic [OUT_W-1:0]  MAX_OUT = OUT_W'(MAX_OUTSTANDING_P);

  // Control state
  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [PTR_W_P-1:0]          r_issue_ptr;
  logic [PTR_W_P-1:0]          r_commit_tail;
  logic [OUT_W-1:0]            r_outstanding;
  logic                        r_hold_valid;
  logic                        r_tail_update;

  // Hold register payload (data path, not reset)
  addr_t                       r_hold_addr;
  logic [DATABUS_WIDTH_P-1:0]  r_hold_data;

  // Combinational helpers
  logic [PTR_W_P-1:0]          w_qsize;
  logic [PTR_W_P-1:0]          w_issue_next;
  logic [PTR_W_P-1:0]          w_commit_next;
  logic                        w_full;
  logic                        w_run;
  logic                        w_handoff;
  logic                        w_accept;
  logic                        w_ack_ok;
  logic                        w_acc_ready;
  logic                        w_drained;
  addr_t                       w_elem_addr;

  assign w_qsize = fifo_config_r.queue_size;

  ring_ptr_inc #(
    .WIDTH_P (PTR_W_P)
  ) u_issue_inc (
    .i_ptr  (r_issue_ptr),
    .i_size (w_qsize),
    .o_next (w_issue_next)
  );

  ring_ptr_inc #(
    .WIDTH_P (PTR_W_P)
  ) u_commit_inc (
    .i_ptr  (r_commit_tail),
    .i_size (w_qsize),
    .o_next (w_commit_next)
  );

  // One slot is always kept free so head == tail means empty
  assign w_full = (w_issue_next == consumer_head);

  // Address of the element that would be accepted this cycle
  assign w_elem_addr = fifo_config_r.addr_base
                     + (addr_t'(r_issue_ptr) << stride_shift(fifo_config_r.element_size));

  // The hold entry leaves only when both adapter readys are up together
  assign w_handoff = r_hold_valid & trans.ready & acc_data.ready;

  assign w_acc_ready = w_run
                     & ~w_full
                     & (r_outstanding < MAX_OUT)
                     & (~r_hold_valid | w_handoff);

  assign w_accept  = acc_in.valid & w_acc_ready;

  // Acks with nothing outstanding (e.g. a store that straddled a reset) are dropped
  assign w_ack_ok  = trans_ack & (r_outstanding != '0);

  assign w_drained = (r_outstanding == '0) & ~r_hold_valid;

  // Valids come only from the hold flag so they never depend on the adapter readys
  assign acc_in.ready  = w_acc_ready;
  assign trans.valid   = r_hold_valid;
  assign trans.data    = r_hold_addr;
  assign acc_data.valid = r_hold_valid;
  assign acc_data.data  = r_hold_data;
  assign commit_tail   = r_commit_tail;
  assign tail_update   = r_tail_update;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: IDLE -> RUN on enable, RUN -> DRAIN on disable, DRAIN -> IDLE once empty
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (enable)    w_state_nxt = S_RUN;
      S_RUN:   if (!enable)   w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_drained) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: accepting stops in the same cycle enable falls
  always_comb begin
    w_run = 1'b0;
    idle  = 1'b0;
    case (r_state)
      S_IDLE:  idle  = 1'b1;
      S_RUN:   w_run = enable;
      default: ;
    endcase
  end

  // Issue pointer advances on every accepted element
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_ptr <= '0;
    end else if (w_accept) begin
      r_issue_ptr <= w_issue_next;
    end
  end

  // Commit pointer advances on every valid ack and flags the change one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_tail <= '0;
      r_tail_update <= 1'b0;
    end else begin
      r_tail_update <= w_ack_ok;
      if (w_ack_ok) begin
        r_commit_tail <= w_commit_next;
      end
    end
  end

  // Outstanding count covers the held element plus everything issued but not acked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, w_ack_ok})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Hold valid: set on accept, cleared on handoff; accept wins when both occur
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
    end else if (w_handoff) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Hold payload: address and data of the accepted element travel as one entry
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold_addr <= w_elem_addr;
      r_hold_data <= acc_in.data;
    end
  end

  // Element size must be one of the supported strides while the producer runs
  a_size_legal : assert property (
    @(posedge clk) disable iff (!rst_n)
    (r_state != S_IDLE) |-> size_legal(fifo_config_r.element_size)
  ) else $error("producer_addr_gen: illegal element_size %0d", fifo_config_r.element_size);

  // The adapter must raise both readys together
  a_ready_pair : assert property (
    @(posedge clk) disable iff (!rst_n)
    r_hold_valid |-> (trans.ready == acc_data.ready)
  ) else $error("producer_addr_gen: one-sided adapter ready");

  // An ack with nothing outstanding is dropped; flag it without stopping
  a_ack_outstanding : assert property (
    @(posedge clk) disable iff (!rst_n)
    trans_ack |-> (r_outstanding != '0)
  ) else $warning("producer_addr_gen: trans_ack with no outstanding element ignored");

endmodule : producer_addr_gen
